uart_tx: RTL and testbench

Byte-serial UART transmitter: accepts bytes over a valid/ready handshake into a small FIFO and shifts them out as 8N1 frames on a single serial line. It is the transmit-side companion of the analyzer's UART receiver and uses the same `CLKS_PER_BIT` bit-timing convention, so one parameter value serves both directions. Its main job is returning captured sample data and status bytes to the host.

---
 rtl/uart_tx.sv | 183 ++++++++++++++++++
 tb/tb_uart_tx.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// uart_tx: byte FIFO feeding an 8N1 serial transmitter.
// Shares the CLKS_PER_BIT bit-timing convention with the receiver.
module uart_tx #(
  parameter int CLKS_PER_BIT = 87,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       i_Clock,
  input  logic       i_Rst_n,
  input  logic       i_Tx_DV,
  input  logic [7:0] i_Tx_Byte,
  output logic       o_Tx_Ready,
  output logic       o_Tx_Serial,
  output logic       o_Tx_Active,
  output logic       o_Tx_Done
);

  localparam int CW =
    (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int AW =
    (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  localparam logic [CW-1:0] CLK_LAST =
    CW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0] FIFO_FULL =
    (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          serial_q, serial_d;
  logic          active_q, active_d;
  logic          done_q, done_d;
  logic          ready_q, ready_d;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;

  logic push;
  logic pop;
  logic bit_end;
  logic fifo_nempty;

  assign push        = i_Tx_DV && ready_q;
  assign bit_end     = (clk_cnt_q == CLK_LAST);
  assign fifo_nempty = (count_q != '0);

  // Frame sequencing: next state, bit timing and FIFO pops.
  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    done_d    = 1'b0;
    pop       = 1'b0;
    unique case (state_q)
      IDLE: begin
        clk_cnt_d = '0;
        if (fifo_nempty) begin
          pop       = 1'b1;
          shift_d   = mem_q[rd_ptr_q];
          bit_idx_d = '0;
          state_d   = START;
        end
      end
      START: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          state_d   = DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          shift_d   = {1'b0, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          done_d    = 1'b1;
          if (fifo_nempty) begin
            pop       = 1'b1;
            shift_d   = mem_q[rd_ptr_q];
            bit_idx_d = '0;
            state_d   = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d   = IDLE;
        clk_cnt_d = '0;
      end
    endcase
  end

  // FIFO pointer and occupancy bookkeeping.
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    ready_d = (count_d != FIFO_FULL);
  end

  // Output levels follow the state being entered.
  always_comb begin
    serial_d = 1'b1;
    unique case (state_d)
      START:   serial_d = 1'b0;
      DATA:    serial_d = shift_d[0];
      default: serial_d = 1'b1;
    endcase
    active_d = (state_d != IDLE);
  end

  // Byte storage; contents need no reset.
  always_ff @(posedge i_Clock) begin
    if (push) begin
      mem_q[wr_ptr_q] <= i_Tx_Byte;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q   <= IDLE;
      clk_cnt_q <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      serial_q  <= 1'b1;
      active_q  <= 1'b0;
      done_q    <= 1'b0;
      ready_q   <= 1'b1;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      serial_q  <= serial_d;
      active_q  <= active_d;
      done_q    <= done_d;
      ready_q   <= ready_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

  assign o_Tx_Ready  = ready_q;
  assign o_Tx_Serial = serial_q;
  assign o_Tx_Active = active_q;
  assign o_Tx_Done   = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: scoreboard bench for uart_tx.
// A serial monitor decodes frames and pops expected bytes.
module tb_uart_tx;

  localparam int C = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       dv = 1'b0;
  logic [7:0] tx_byte = '0;
  logic       ready, serial, active, done;

  logic       dv2 = 1'b0;
  logic [7:0] tx_byte2 = '0;
  logic       ready2, serial2, active2, done2;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  logic [7:0] exp_q[$];
  int         done_t[$];

  uart_tx #(.CLKS_PER_BIT(C), .FIFO_DEPTH(4)) dut (
    .i_Clock    (clk),
    .i_Rst_n    (rst_n),
    .i_Tx_DV    (dv),
    .i_Tx_Byte  (tx_byte),
    .o_Tx_Ready (ready),
    .o_Tx_Serial(serial),
    .o_Tx_Active(active),
    .o_Tx_Done  (done)
  );

  uart_tx #(.CLKS_PER_BIT(2), .FIFO_DEPTH(2)) dut2 (
    .i_Clock    (clk),
    .i_Rst_n    (rst_n),
    .i_Tx_DV    (dv2),
    .i_Tx_Byte  (tx_byte2),
    .o_Tx_Ready (ready2),
    .o_Tx_Serial(serial2),
    .o_Tx_Active(active2),
    .o_Tx_Done  (done2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (done === 1'b1) done_t.push_back(cyc);
  end

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after acceptance.
  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    dv = 1'b1;
    tx_byte = b;
    while (ready !== 1'b1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (ready === 1'b1) exp_q.push_back(b);
    else chk("send timeout", 32'(ready), 32'd1);
    @(negedge clk);
    dv = 1'b0;
  endtask

  task automatic send_lat(input logic [7:0] b, input string tag);
    send(b);
    chk({tag, " serial at E0"}, 32'(serial), 32'd1);
    chk({tag, " active at E0"}, 32'(active), 32'd0);
    @(negedge clk);
    chk({tag, " serial at E1"}, 32'(serial), 32'd0);
    chk({tag, " active at E1"}, 32'(active), 32'd1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || active !== 1'b0)
           && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("drain queue", 32'(exp_q.size()), 32'd0);
    repeat (4) @(negedge clk);
  endtask

  // Decode one frame starting at the current negedge.
  task automatic rx_frame(output bit more);
    logic [9:0] bits;
    bit stable, quiet;
    more = 1'b0;
    stable = 1'b1;
    quiet = 1'b1;
    bits = '0;
    for (int b = 0; b < 10; b++) begin
      for (int c = 0; c < C; c++) begin
        if (b != 0 || c != 0) @(negedge clk);
        if (!rst_n) return;
        if (c == 0) bits[b] = serial;
        else if (serial !== bits[b]) stable = 1'b0;
        if (active !== 1'b1) stable = 1'b0;
        if ((b != 0 || c != 0) && done !== 1'b0)
          quiet = 1'b0;
      end
    end
    chk("bit level stable", 32'(stable), 32'd1);
    chk("done quiet in frame", 32'(quiet), 32'd1);
    chk("start bit", 32'(bits[0]), 32'd0);
    chk("stop bit", 32'(bits[9]), 32'd1);
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL unexpected frame: got %0h want none",
               bits[8:1]);
    end else begin
      chk("rx byte", 32'(bits[8:1]), 32'(exp_q.pop_front()));
    end
    @(negedge clk);
    if (!rst_n) return;
    chk("done pulse", 32'(done), 32'd1);
    if (serial === 1'b0) begin
      chk("b2b active", 32'(active), 32'd1);
      more = 1'b1;
    end else begin
      chk("active drop", 32'(active), 32'd0);
      @(negedge clk);
      if (!rst_n) return;
      chk("done width", 32'(done), 32'd0);
      more = (serial === 1'b0);
    end
  endtask

  // Monitor: waits for a start bit and checks frames.
  initial begin
    bit more;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && serial === 1'b0) begin
        do rx_frame(more); while (more);
      end
    end
  end

  initial begin
    logic [9:0] fr;
    bit ok2;
    bit prev_rdy;
    int n;

    repeat (3) @(negedge clk);
    chk("rst serial", 32'(serial), 32'd1);
    chk("rst active", 32'(active), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst ready", 32'(ready), 32'd1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single byte, latency checked around E0/E1.
    send_lat(8'hA5, "single");
    wait_idle();

    // Back-to-back frames, done pulses 10*C apart.
    done_t.delete();
    send(8'h00);
    send(8'hFF);
    wait_idle();
    chk("b2b done count", 32'(done_t.size()), 32'd2);
    if (done_t.size() == 2)
      chk("b2b done spacing",
          32'(done_t[1] - done_t[0]), 32'(10 * C));

    // Fill the FIFO while the first byte is on the line.
    send(8'h11);
    @(negedge clk);
    send(8'h22);
    send(8'h33);
    send(8'h44);
    chk("ready before full", 32'(ready), 32'd1);
    send(8'h55);
    chk("ready when full", 32'(ready), 32'd0);
    dv = 1'b1;
    tx_byte = 8'h66;
    repeat (5) @(negedge clk);
    chk("ready held low", 32'(ready), 32'd0);
    dv = 1'b0;
    n = 0;
    prev_rdy = ready;
    while (done !== 1'b1 && n < 200) begin
      prev_rdy = ready;
      @(negedge clk);
      n++;
    end
    chk("ready before pop", 32'(prev_rdy), 32'd0);
    chk("ready after pop", 32'(ready), 32'd1);
    wait_idle();

    // Reset during DATA bit 3 with two bytes queued.
    send(8'hC3);
    send(8'h12);
    send(8'h34);
    repeat (15) @(negedge clk);
    #1 rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("mid rst serial", 32'(serial), 32'd1);
    chk("mid rst active", 32'(active), 32'd0);
    chk("mid rst done", 32'(done), 32'd0);
    chk("mid rst ready", 32'(ready), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    chk("post rst line", 32'(serial), 32'd1);
    chk("post rst active", 32'(active), 32'd0);
    send_lat(8'h5A, "after rst");
    wait_idle();

    // Minimum bit time on the second instance.
    fr = {1'b1, 8'h01, 1'b0};
    ok2 = 1'b1;
    dv2 = 1'b1;
    tx_byte2 = 8'h01;
    @(negedge clk);
    dv2 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (serial2 !== fr[i / 2]) ok2 = 1'b0;
      if (active2 !== 1'b1 || done2 !== 1'b0) ok2 = 1'b0;
    end
    chk("min frame shape", 32'(ok2), 32'd1);
    @(negedge clk);
    chk("min done", 32'(done2), 32'd1);
    chk("min active drop", 32'(active2), 32'd0);
    chk("min line idle", 32'(serial2), 32'd1);
    repeat (4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
